// File: rtl/cachepool_l1_coalescer.sv
// Coalesces word requests that hit the same cache line into one line-level request
// for a CachePool L1 controller port, using a single staging entry.
module cachepool_l1_coalescer #(
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned LineWidth  = 256,
  parameter int unsigned CoalFactor = 2,
  parameter int unsigned Window     = 2,
  parameter int unsigned IdWidth    = 6
) (
  input  logic                                              clk_i,
  input  logic                                              rst_ni,
  input  logic                                              req_valid_i,
  output logic                                              req_ready_o,
  input  logic [AddrWidth-1:0]                              req_addr_i,
  input  logic                                              req_we_i,
  input  logic [DataWidth-1:0]                              req_data_i,
  input  logic [DataWidth/8-1:0]                            req_be_i,
  input  logic [IdWidth-1:0]                                req_id_i,
  output logic                                              line_valid_o,
  input  logic                                              line_ready_i,
  output logic [AddrWidth-1:0]                              line_addr_o,
  output logic                                              line_we_o,
  output logic [LineWidth-1:0]                              line_data_o,
  output logic [LineWidth/8-1:0]                            line_be_o,
  output logic [$clog2(CoalFactor+1)-1:0]                   line_cnt_o,
  output logic [CoalFactor*IdWidth-1:0]                     line_id_o,
  output logic [CoalFactor*$clog2(LineWidth/DataWidth)-1:0] line_word_o
);

  localparam int unsigned Words    = LineWidth / DataWidth;
  localparam int unsigned DBytes   = DataWidth / 8;
  localparam int unsigned LBytes   = LineWidth / 8;
  localparam int unsigned LineOff  = $clog2(LBytes);
  localparam int unsigned WordOff  = $clog2(DBytes);
  localparam int unsigned WordIdxW = $clog2(Words);
  localparam int unsigned CntW     = $clog2(CoalFactor + 1);
  localparam int unsigned TimerW   = $clog2(Window) + 1;
  localparam int unsigned IdsW     = CoalFactor * IdWidth;
  localparam int unsigned WordsW   = CoalFactor * WordIdxW;

  typedef enum logic [1:0] {
    EMPTY,
    COLLECT,
    SEND
  } state_e;

  state_e                state_q;
  logic [AddrWidth-1:0]  addr_q;
  logic                  we_q;
  logic [CntW-1:0]       cnt_q;
  logic [TimerW-1:0]     timer_q;
  logic [LineWidth-1:0]  data_q;
  logic [LBytes-1:0]     be_q;
  logic [IdsW-1:0]       ids_q;
  logic [WordsW-1:0]     words_q;

  logic [AddrWidth-1:0]  req_line;
  logic [WordIdxW-1:0]   req_word;
  logic [DataWidth-1:0]  req_mask_w;
  logic [LBytes-1:0]     req_be_line;
  logic [LineWidth-1:0]  req_data_line;
  logic [LineWidth-1:0]  req_mask_line;
  logic                  mergeable;
  logic                  addr_unused;

  assign addr_unused = ^req_addr_i[WordOff-1:0];

  // Incoming word is shifted into its line slot; data is merged bytewise so that
  // non-overlapping partial writes to the same word keep each other's bytes.
  always_comb begin
    req_line = {req_addr_i[AddrWidth-1:LineOff], {LineOff{1'b0}}};
    req_word = req_addr_i[LineOff-1:WordOff];
    req_mask_w = '0;
    for (int unsigned b = 0; b < DBytes; b++) begin
      req_mask_w[b*8 +: 8] = {8{req_be_i[b]}};
    end
    req_be_line   = LBytes'(req_be_i) << (DBytes * req_word);
    req_data_line = LineWidth'(req_data_i) << (DataWidth * req_word);
    req_mask_line = LineWidth'(req_mask_w) << (DataWidth * req_word);
  end

  always_comb begin
    mergeable = req_valid_i
             && (req_line == addr_q)
             && (req_we_i == we_q)
             && (cnt_q < CntW'(CoalFactor))
             && (!req_we_i || ((req_be_line & be_q) == '0));
  end

  always_comb begin
    case (state_q)
      EMPTY:   req_ready_o = 1'b1;
      COLLECT: req_ready_o = mergeable;
      SEND:    req_ready_o = line_ready_i;
      default: req_ready_o = 1'b0;
    endcase
  end

  assign line_valid_o = (state_q == SEND);
  assign line_addr_o  = addr_q;
  assign line_we_o    = we_q;
  assign line_data_o  = data_q;
  assign line_be_o    = be_q;
  assign line_cnt_o   = cnt_q;
  assign line_id_o    = ids_q;
  assign line_word_o  = words_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      addr_q  <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      timer_q <= '0;
      data_q  <= '0;
      be_q    <= '0;
      ids_q   <= '0;
      words_q <= '0;
    end else begin
      case (state_q)
        EMPTY, SEND: begin
          if (state_q == EMPTY || line_ready_i) begin
            if (req_valid_i) begin
              state_q <= COLLECT;
              addr_q  <= req_line;
              we_q    <= req_we_i;
              cnt_q   <= CntW'(1);
              timer_q <= '0;
              data_q  <= req_data_line & req_mask_line;
              be_q    <= req_be_line;
              ids_q   <= IdsW'(req_id_i);
              words_q <= WordsW'(req_word);
            end else begin
              state_q <= EMPTY;
            end
          end
        end
        COLLECT: begin
          if (mergeable) begin
            data_q  <= (data_q & ~req_mask_line) | (req_data_line & req_mask_line);
            be_q    <= be_q | req_be_line;
            ids_q   <= ids_q | (IdsW'(req_id_i) << (IdWidth * cnt_q));
            words_q <= words_q | (WordsW'(req_word) << (WordIdxW * cnt_q));
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q + 1'b1 == CntW'(CoalFactor)) begin
              state_q <= SEND;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
            // Without a merge, any valid request here is non-mergeable and forces SEND.
            if (timer_q == TimerW'(Window - 1) || req_valid_i) begin
              state_q <= SEND;
            end
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_cachepool_l1_coalescer.sv
// Self-checking bench for cachepool_l1_coalescer: vector table plus scoreboard of
// expected line requests, with hand-written backpressure and reset sequences.
module tb_cachepool_l1_coalescer;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [63:0] data;
    logic [7:0]  be;
    logic [5:0]  id;
  } req_t;

  typedef struct {
    logic [31:0]  addr;
    logic         we;
    logic [1:0]   cnt;
    logic [31:0]  be;
    logic [255:0] data;
    logic [11:0]  ids;
    logic [3:0]   words;
  } line_t;

  typedef struct {
    req_t  r0;
    req_t  r1;
    bit    two;
    int    stall;
    line_t e0;
    line_t e1;
    int    ne;
    int    lat;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic         req_we;
  logic [63:0]  req_data;
  logic [7:0]   req_be;
  logic [5:0]   req_id;
  logic         line_valid;
  logic         line_ready;
  logic [31:0]  line_addr;
  logic         line_we;
  logic [255:0] line_data;
  logic [31:0]  line_be;
  logic [1:0]   line_cnt;
  logic [11:0]  line_id;
  logic [3:0]   line_word;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    last_acc_cyc = 0;
  int    last_hs_cyc = 0;
  line_t exp_q[$];
  line_t mon_e;
  vec_t  vecs[7];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cachepool_l1_coalescer #(
    .AddrWidth (32),
    .DataWidth (64),
    .LineWidth (256),
    .CoalFactor(2),
    .Window    (2),
    .IdWidth   (6)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_we_i    (req_we),
    .req_data_i  (req_data),
    .req_be_i    (req_be),
    .req_id_i    (req_id),
    .line_valid_o(line_valid),
    .line_ready_i(line_ready),
    .line_addr_o (line_addr),
    .line_we_o   (line_we),
    .line_data_o (line_data),
    .line_be_o   (line_be),
    .line_cnt_o  (line_cnt),
    .line_id_o   (line_id),
    .line_word_o (line_word)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic req_t mk_req(logic [31:0] a, logic w, logic [63:0] d, logic [7:0] b,
                                  logic [5:0] i);
    req_t r;
    r.addr = a; r.we = w; r.data = d; r.be = b; r.id = i;
    return r;
  endfunction

  function automatic line_t mk_line(logic [31:0] a, logic w, logic [1:0] c, logic [31:0] b,
                                    logic [255:0] d, logic [11:0] i, logic [3:0] wd);
    line_t l;
    l.addr = a; l.we = w; l.cnt = c; l.be = b; l.data = d; l.ids = i; l.words = wd;
    return l;
  endfunction

  // Scoreboard: every line handshake pops the oldest expected line request.
  always @(negedge clk) begin
    if (rst_n && line_valid && line_ready) begin
      last_hs_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_line actual_addr=%0h required=none", line_addr);
      end else begin
        mon_e = exp_q.pop_front();
        check("line_addr", line_addr, mon_e.addr);
        check("line_we", line_we, mon_e.we);
        check("line_cnt", line_cnt, mon_e.cnt);
        check("line_be", line_be, mon_e.be);
        check("line_data", line_data, mon_e.data);
        check("line_id", line_id, mon_e.ids);
        check("line_word", line_word, mon_e.words);
      end
    end
  end

  task automatic do_req(input req_t r, output int stall);
    bit acc;
    acc = 0;
    stall = 0;
    req_valid = 1'b1;
    req_addr = r.addr; req_we = r.we; req_data = r.data; req_be = r.be; req_id = r.id;
    for (int c = 0; c < 40 && !acc; c++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = 1;
        last_acc_cyc = cyc;
      end else begin
        stall++;
      end
      @(posedge clk);
      #1;
    end
    if (!acc) check("req_accept_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) @(negedge clk);
    check("drain_queue", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, line_valid, 0);
    check({tag, "_ready"}, req_ready, 1);
    check({tag, "_zero_outs"}, {line_addr, line_we, line_be, line_cnt, line_id, line_word}, 0);
    check({tag, "_zero_data"}, line_data, 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int s;
    exp_q.push_back(v.e0);
    if (v.ne == 2) exp_q.push_back(v.e1);
    do_req(v.r0, s);
    if (v.two) begin
      do_req(v.r1, s);
      check($sformatf("v%0d_stall", idx), s, v.stall);
    end
    req_valid = 1'b0;
    drain();
    check($sformatf("v%0d_latency", idx), last_hs_cyc - last_acc_cyc, v.lat);
  endtask

  initial begin
    int s;
    req_t pend;

    vecs[0] = '{r0: mk_req(32'h5180_0008, 0, 64'h0, 8'hFF, 6'd3),
                r1: mk_req(32'h5180_0010, 0, 64'h0, 8'hFF, 6'd5), two: 1, stall: 0,
                e0: mk_line(32'h5180_0000, 0, 2, 32'h00FF_FF00, 256'h0, 12'h143, 4'h9),
                e1: mk_line(0, 0, 0, 0, 0, 0, 0), ne: 1, lat: 1};
    vecs[1] = '{r0: mk_req(32'h5180_0000, 0, 64'h0, 8'hFF, 6'd1),
                r1: mk_req(32'h5180_0020, 0, 64'h0, 8'hFF, 6'd2), two: 1, stall: 1,
                e0: mk_line(32'h5180_0000, 0, 1, 32'h0000_00FF, 256'h0, 12'h001, 4'h0),
                e1: mk_line(32'h5180_0020, 0, 1, 32'h0000_00FF, 256'h0, 12'h002, 4'h0),
                ne: 2, lat: 3};
    vecs[2] = '{r0: mk_req(32'h5180_0018, 1, 64'hDEAD_BEEF_0123_4567, 8'hFF, 6'd7),
                r1: mk_req(0, 0, 0, 0, 0), two: 0, stall: 0,
                e0: mk_line(32'h5180_0000, 1, 1, 32'hFF00_0000,
                            {64'hDEAD_BEEF_0123_4567, 192'h0}, 12'h007, 4'h3),
                e1: mk_line(0, 0, 0, 0, 0, 0, 0), ne: 1, lat: 3};
    vecs[3] = '{r0: mk_req(32'h5180_0000, 1, 64'h0000_0000_1111_1111, 8'h0F, 6'd1),
                r1: mk_req(32'h5180_0000, 1, 64'h0000_0000_2222_0000, 8'h0C, 6'd2),
                two: 1, stall: 1,
                e0: mk_line(32'h5180_0000, 1, 1, 32'h0F, {192'h0, 64'h1111_1111}, 12'h001, 4'h0),
                e1: mk_line(32'h5180_0000, 1, 1, 32'h0C, {192'h0, 64'h2222_0000}, 12'h002, 4'h0),
                ne: 2, lat: 3};
    vecs[4] = '{r0: mk_req(32'h5180_0000, 1, 64'h0000_0000_1111_1111, 8'h0F, 6'd1),
                r1: mk_req(32'h5180_0000, 1, 64'h2222_2222_0000_0000, 8'hF0, 6'd2),
                two: 1, stall: 0,
                e0: mk_line(32'h5180_0000, 1, 2, 32'hFF, {192'h0, 64'h2222_2222_1111_1111},
                            12'h081, 4'h0),
                e1: mk_line(0, 0, 0, 0, 0, 0, 0), ne: 1, lat: 1};
    vecs[5] = '{r0: mk_req(32'h5180_0000, 0, 64'h0, 8'hFF, 6'd4),
                r1: mk_req(32'h5180_0008, 1, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 6'd6),
                two: 1, stall: 1,
                e0: mk_line(32'h5180_0000, 0, 1, 32'hFF, 256'h0, 12'h004, 4'h0),
                e1: mk_line(32'h5180_0000, 1, 1, 32'hFF00,
                            {128'h0, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0}, 12'h006, 4'h1),
                ne: 2, lat: 3};
    vecs[6] = '{r0: mk_req(32'h5180_0008, 0, 64'h0, 8'hFF, 6'd1),
                r1: mk_req(32'h5180_0008, 0, 64'h0, 8'hFF, 6'd2), two: 1, stall: 0,
                e0: mk_line(32'h5180_0000, 0, 2, 32'hFF00, 256'h0, 12'h081, 4'h5),
                e1: mk_line(0, 0, 0, 0, 0, 0, 0), ne: 1, lat: 1};

    rst_n = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_data = '0; req_be = '0; req_id = '0;
    line_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Backpressure: SEND held for five cycles with a request waiting.
    line_ready = 1'b0;
    exp_q.push_back(mk_line(32'h5180_0040, 0, 1, 32'hFF, 256'h0, 12'h009, 4'h0));
    do_req(mk_req(32'h5180_0040, 0, 64'h0, 8'hFF, 6'd9), s);
    req_valid = 1'b0;
    for (int c = 0; c < 10 && !line_valid; c++) @(negedge clk);
    check("bp_valid_rise", line_valid, 1);
    @(posedge clk);
    #1;
    pend = mk_req(32'h5180_0060, 0, 64'h0, 8'hFF, 6'd10);
    req_valid = 1'b1; req_addr = pend.addr; req_we = pend.we; req_data = pend.data;
    req_be = pend.be; req_id = pend.id;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_hold_valid", line_valid, 1);
      check("bp_hold_ready", req_ready, 0);
      check("bp_hold_addr", line_addr, 32'h5180_0040);
      check("bp_hold_id_be_cnt", {line_id, line_be, line_cnt}, {12'h009, 32'hFF, 2'd1});
      @(posedge clk);
      #1;
    end
    line_ready = 1'b1;
    exp_q.push_back(mk_line(32'h5180_0060, 0, 1, 32'hFF, 256'h0, 12'h00A, 4'h0));
    do_req(pend, s);
    check("bp_release_stall", s, 0);
    req_valid = 1'b0;
    @(negedge clk);
    check("bp_new_entry_collect", line_valid, 0);
    drain();
    check("bp_new_entry_latency", last_hs_cyc - last_acc_cyc, 3);

    // Reset while collecting with one request in the entry.
    do_req(mk_req(32'h5180_0080, 0, 64'h0, 8'hFF, 6'd11), s);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("postreset_no_line", line_valid, 0);
    end
    @(posedge clk);
    #1;
    exp_q.push_back(mk_line(32'h5180_00A0, 0, 1, 32'hFF, 256'h0, 12'h00C, 4'h0));
    do_req(mk_req(32'h5180_00A0, 0, 64'h0, 8'hFF, 6'd12), s);
    req_valid = 1'b0;
    drain();
    check("postreset_latency", last_hs_cyc - last_acc_cyc, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
